// File: rtl/rice_bus_sram_slave.sv
// Single-port word SRAM responder for the core data bus, with a configurable response latency.
// Define RICE_BUS_SRAM_ERROR_EN to flag out-of-range accesses; otherwise the word index wraps modulo DEPTH.
module rice_bus_sram_slave #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 1024,
    parameter logic [XLEN-1:0] BASE_ADDRESS = '0,
    parameter int              LATENCY      = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_request_valid,
    output logic              o_request_ready,
    input  logic [XLEN-1:0]   i_address,
    input  logic              i_write,
    input  logic [XLEN-1:0]   i_write_data,
    input  logic [XLEN/8-1:0] i_strobe,
    output logic              o_response_valid,
    input  logic              i_response_ready,
    output logic [XLEN-1:0]   o_read_data,
    output logic              o_error
);
    localparam int NB       = XLEN / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam bit LAT1     = (LATENCY == 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic             r_write;
    logic             r_err;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_index;
    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [XLEN-1:0]  r_ram_q;

    logic [XLEN-1:0]  w_offset;
    logic [IDX_W-1:0] w_word_index;
    logic [IDX_W-1:0] w_rd_index;
    logic             w_oob;
    logic             w_accept;
    logic             w_we;
    logic             w_rd_en;
    logic             w_unused;

    assign w_offset     = i_address - BASE_ADDRESS;
    assign w_word_index = w_offset[ADDR_LSB +: IDX_W];

`ifdef RICE_BUS_SRAM_ERROR_EN
    assign w_oob    = |(w_offset >> (ADDR_LSB + IDX_W));
    assign w_unused = &{1'b0, w_offset[ADDR_LSB-1:0]};
`else
    assign w_oob    = 1'b0;
    assign w_unused = &{1'b0, w_offset};
`endif

    assign w_accept   = (r_state == S_IDLE) && i_request_valid;
    assign w_we       = w_accept && i_write && !w_oob;
    // The load word is read on the edge that enters RESP, so it is the accept edge when LATENCY is 1.
    assign w_rd_en    = (w_accept && !i_write && LAT1) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1) && !r_write);
    assign w_rd_index = (r_state == S_IDLE) ? w_word_index : r_index;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (w_we && i_strobe[b]) begin
                r_mem[w_word_index][b*8 +: 8] <= i_write_data[b*8 +: 8];
            end
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_index];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
            r_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_request_valid) begin
                        r_index <= w_word_index;
                        r_write <= i_write;
                        r_err   <= w_oob;
                        r_ready <= 1'b0;
                        if (LAT1) begin
                            r_state <= S_RESP;
                            r_valid <= 1'b1;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        r_valid <= 1'b1;
                    end
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    if (i_response_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_request_ready  = r_ready;
    assign o_response_valid = r_valid;
    // Stores and faulted accesses return zero; loads expose the registered RAM word while in RESP.
    assign o_read_data      = (r_valid && !r_write && !r_err) ? r_ram_q : '0;
    assign o_error          = r_valid && r_err;

endmodule

// File: tb/tb_rice_bus_sram_slave.sv
// Directed bench: instance 0 runs with LATENCY=1, instance 1 with LATENCY=4.
module tb_rice_bus_sram_slave;
    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] addr;
    logic [1:0]       wr;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  strb;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;

    int checks = 0;
    int errors = 0;

    rice_bus_sram_slave #(.XLEN(32), .DEPTH(1024), .BASE_ADDRESS(32'h0), .LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_request_valid(req_valid[0]), .o_request_ready(req_ready[0]),
        .i_address(addr[0]), .i_write(wr[0]), .i_write_data(wdata[0]), .i_strobe(strb[0]),
        .o_response_valid(resp_valid[0]), .i_response_ready(resp_ready[0]),
        .o_read_data(rdata[0]), .o_error(err[0])
    );

    rice_bus_sram_slave #(.XLEN(32), .DEPTH(1024), .BASE_ADDRESS(32'h0), .LATENCY(4)) dut_l4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_request_valid(req_valid[1]), .o_request_ready(req_ready[1]),
        .i_address(addr[1]), .i_write(wr[1]), .i_write_data(wdata[1]), .i_strobe(strb[1]),
        .o_response_valid(resp_valid[1]), .i_response_ready(resp_ready[1]),
        .o_read_data(rdata[1]), .o_error(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request, waits for the response, optionally stalls it, then completes the handshake.
    task automatic do_txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int hold, input int exp_lat,
                          output logic [31:0] rd, output logic er);
        int cyc;
        @(negedge clk);
        checks++;
        if (req_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready dut%0d got %b want 1", s, req_ready[s]);
        end
        req_valid[s] = 1'b1; wr[s] = w; addr[s] = a; wdata[s] = d; strb[s] = st;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        cyc = 1;
        while (resp_valid[s] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != exp_lat) begin
            errors++;
            $display("FAIL latency dut%0d got %0d want %0d", s, cyc, exp_lat);
        end
        rd = rdata[s];
        er = err[s];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_valid[s] !== 1'b1 || rdata[s] !== rd || err[s] !== er || req_ready[s] !== 1'b0) begin
                errors++;
                $display("FAIL hold dut%0d valid=%b data=%h err=%b ready=%b want valid=1 data=%h err=%b ready=0",
                         s, resp_valid[s], rdata[s], err[s], req_ready[s], rd, er);
            end
        end
        resp_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[s] = 1'b0;
        checks++;
        if (resp_valid[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake dut%0d valid=%b ready=%b want valid=0 ready=1",
                     s, resp_valid[s], req_ready[s]);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1 || resp_valid[s] !== 1'b0 || rdata[s] !== 32'h0 || err[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                         s, req_ready[s], resp_valid[s], rdata[s], err[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1 || resp_valid[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d ready=%b valid=%b want 1 0", s, req_ready[s], resp_valid[s]);
            end
        end
    endtask

    task automatic test_latency1();
        logic [31:0] d;
        logic e;
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL l1_store_resp data=%h err=%b want 00000000 0", d, e);
        end
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1, d, e);
        checks++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL l1_load data=%h err=%b want deadbeef 0", d, e);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] d;
        logic e;
        do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1, d, e);
        do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1, d, e);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1, d, e);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL partial_store got %h want 11bb33dd", d);
        end
        do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 1, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_strobe_resp data=%h err=%b want 00000000 0", d, e);
        end
        do_txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 1, d, e);
        checks++;
        if (d !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL zero_strobe_load got %h want 11bb33dd", d);
        end
    endtask

    task automatic test_latency4();
        logic [31:0] d;
        logic e;
        do_txn(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 4, d, e);
        do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 3, 4, d, e);
        checks++;
        if (d !== 32'h12345678 || e !== 1'b0) begin
            errors++;
            $display("FAIL l4_load data=%h err=%b want 12345678 0", d, e);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        logic e;
        do_txn(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0, 1, d, e);
        do_txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, 1, d, e);
`ifdef RICE_BUS_SRAM_ERROR_EN
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL range_store err=%b data=%h want 1 00000000", e, d);
        end
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1, d, e);
        checks++;
        if (d !== 32'h01020304) begin
            errors++;
            $display("FAIL range_word0 got %h want 01020304", d);
        end
`else
        checks++;
        if (e !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL wrap_store err=%b data=%h want 0 00000000", e, d);
        end
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1, d, e);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_word0 got %h want cafef00d", d);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] d;
        logic e;
        @(negedge clk);
        req_valid[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; wdata[1] = 32'h0; strb[1] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        wr[1] = 1'b1; addr[1] = 32'h44; wdata[1] = 32'h00000055; strb[1] = 4'hF;
        cyc = 1;
        while (resp_valid[1] !== 1'b1 && cyc < 40) begin
            checks++;
            if (req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_wait_ready got %b want 0", req_ready[1]);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 4 || rdata[1] !== 32'h12345678 || req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_resp lat=%0d data=%h ready=%b want 4 12345678 0", cyc, rdata[1], req_ready[1]);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[1] = 1'b0;
        checks++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle valid=%b ready=%b want 0 1", resp_valid[1], req_ready[1]);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept ready=%b want 0", req_ready[1]);
        end
        req_valid[1] = 1'b0;
        cyc = 1;
        while (resp_valid[1] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 4 || rdata[1] !== 32'h0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_resp lat=%0d data=%h err=%b want 4 00000000 0", cyc, rdata[1], err[1]);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[1] = 1'b0;
        do_txn(1, 1'b0, 32'h47, 32'h0, 4'h0, 0, 4, d, e);
        checks++;
        if (d !== 32'h00000055) begin
            errors++;
            $display("FAIL b2b_store_landed got %h want 00000055", d);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        logic e;
        @(negedge clk);
        req_valid[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40; strb[1] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || rdata[1] !== 32'h0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                     req_ready[1], resp_valid[1], rdata[1], err[1]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL midwait_release ready=%b want 1", req_ready[1]);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (resp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL midwait_dropped valid=%b want 0", resp_valid[1]);
        end
        do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 4, d, e);
        checks++;
        if (d !== 32'h12345678) begin
            errors++;
            $display("FAIL midwait_ram_kept got %h want 12345678", d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; wr = '0; addr = '0; wdata = '0; strb = '0; resp_ready = '0;
        repeat (3) @(negedge clk);
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
        test_latency1();
        $display("test_latency1 done: checks=%0d errors=%0d", checks, errors);
        test_partial_store();
        $display("test_partial_store done: checks=%0d errors=%0d", checks, errors);
        test_latency4();
        $display("test_latency4 done: checks=%0d errors=%0d", checks, errors);
        test_range();
        $display("test_range done: checks=%0d errors=%0d", checks, errors);
        test_back_to_back();
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
        test_reset_mid_wait();
        $display("test_reset_mid_wait done: checks=%0d errors=%0d", checks, errors);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
